// File: rtl/popcount_pkg.sv
// Shared types and width helpers for the streaming popcount accumulator.
package popcount_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } pc_state_t;

  // Packet sum width: holds DATA_WIDTH*MAX_BEATS without overflow.
  function automatic int unsigned cnt_w(input int unsigned data_width,
                                        input int unsigned max_beats);
    return $clog2(data_width * max_beats) + 1;
  endfunction

  // Beat counter width: holds MAX_BEATS itself.
  function automatic int unsigned beat_w(input int unsigned max_beats);
    return $clog2(max_beats) + 1;
  endfunction

endpackage

// File: rtl/popcount_word.sv
// Combinational ones counter for a single beat.
module popcount_word #(
  parameter  int unsigned DATA_WIDTH = 16,
  localparam int unsigned CW         = $clog2(DATA_WIDTH) + 1
) (
  input  logic [DATA_WIDTH-1:0] din_i,
  output logic [CW-1:0]         count_o
);

  // Sum of all set bits in the word.
  always_comb begin
    count_o = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      count_o = count_o + CW'(din_i[i]);
    end
  end

endmodule

// File: rtl/popcount_accum.sv
// Streaming per-packet popcount: per-beat count stage, packet accumulator,
// and a held result on a valid/ready output.
module popcount_accum
  import popcount_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 16,
  parameter  int unsigned MAX_BEATS  = 256,
  localparam int unsigned CNT_W      = cnt_w(DATA_WIDTH, MAX_BEATS),
  localparam int unsigned BEAT_W     = beat_w(MAX_BEATS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  in_last,
  input  logic                  count_zeros,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CNT_W-1:0]      dout,
  output logic [BEAT_W-1:0]     out_beats,
  output logic                  out_trunc
);

  localparam int unsigned PW = $clog2(DATA_WIDTH) + 1;

  // Input side / S1 registers
  logic              s1_valid_q, s1_valid_d;
  logic [PW-1:0]     s1_cnt_q,   s1_cnt_d;
  logic              s1_last_q,  s1_last_d;
  logic              s1_trunc_q, s1_trunc_d;
  logic [BEAT_W-1:0] idx_q,      idx_d;
  logic              mode_q,     mode_d;
  logic              in_ready_q, in_ready_d;

  // Accumulator / output registers
  pc_state_t         state_q,     state_d;
  logic [CNT_W-1:0]  sum_q,       sum_d;
  logic [BEAT_W-1:0] beats_q,     beats_d;
  logic              trunc_q,     trunc_d;
  logic              out_valid_q, out_valid_d;
  logic [CNT_W-1:0]  dout_q,      dout_d;
  logic [BEAT_W-1:0] out_beats_q, out_beats_d;
  logic              out_trunc_q, out_trunc_d;

  logic                  accept;
  logic                  first_beat;
  logic                  mode_eff;
  logic                  eff_last;
  logic [DATA_WIDTH-1:0] word;
  logic [PW-1:0]         word_cnt;

  // The first beat uses the live mode input; later beats use the latched one.
  assign accept     = in_valid && in_ready_q;
  assign first_beat = (idx_q == '0);
  assign mode_eff   = first_beat ? count_zeros : mode_q;
  assign word       = mode_eff ? ~din : din;
  assign eff_last   = in_last || (idx_q == BEAT_W'(MAX_BEATS - 1));

  popcount_word #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_word (
    .din_i   (word),
    .count_o (word_cnt)
  );

  // S1 next-state: per-beat count, last/trunc flags, beat index and mode latch.
  always_comb begin
    s1_valid_d = accept;
    s1_cnt_d   = word_cnt;
    s1_last_d  = accept && eff_last;
    s1_trunc_d = accept && eff_last && !in_last;
    idx_d      = idx_q;
    mode_d     = mode_q;
    if (accept) begin
      idx_d = eff_last ? '0 : idx_q + BEAT_W'(1);
      if (first_beat) begin
        mode_d = count_zeros;
      end
    end
  end

  // Packet FSM; result registers load on the first HOLD cycle so out_valid
  // rises two edges after the final beat is accepted.
  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    beats_d     = beats_q;
    trunc_d     = trunc_q;
    out_valid_d = out_valid_q;
    dout_d      = dout_q;
    out_beats_d = out_beats_q;
    out_trunc_d = out_trunc_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (s1_valid_q) begin
          sum_d   = sum_q + CNT_W'(s1_cnt_q);
          beats_d = beats_q + BEAT_W'(1);
          if (s1_last_q) begin
            trunc_d = s1_trunc_q;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          dout_d      = sum_q;
          out_beats_d = beats_q;
          out_trunc_d = trunc_q;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          sum_d       = '0;
          beats_d     = '0;
          trunc_d     = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Block new beats while a packet's final beat is in flight or a result is held.
  assign in_ready_d = (state_d != HOLD) && !(s1_valid_d && s1_last_d);

  // S1 and input-side registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_cnt_q   <= '0;
      s1_last_q  <= 1'b0;
      s1_trunc_q <= 1'b0;
      idx_q      <= '0;
      mode_q     <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_cnt_q   <= s1_cnt_d;
      s1_last_q  <= s1_last_d;
      s1_trunc_q <= s1_trunc_d;
      idx_q      <= idx_d;
      mode_q     <= mode_d;
      in_ready_q <= in_ready_d;
    end
  end

  // FSM, accumulator and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      sum_q       <= '0;
      beats_q     <= '0;
      trunc_q     <= 1'b0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      out_beats_q <= '0;
      out_trunc_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      beats_q     <= beats_d;
      trunc_q     <= trunc_d;
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      out_beats_q <= out_beats_d;
      out_trunc_q <= out_trunc_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign out_beats = out_beats_q;
  assign out_trunc = out_trunc_q;

endmodule
